tdc_fifo_reader: RTL and testbench

Consumer end of the TDC result FIFO. The measurement controller pushes 48-bit words {calib2, calib1, time1} into the FIFO; this block pops one word at a time and splits it into bytes. It hands each byte to the UART transmitter using a new_data/busy handshake, so results leave the FPGA over the serial link. It sits between the result FIFO read port and the serial TX module.

---
 rtl/tdc_pkg.sv | 20 ++
 rtl/tdc_word_serializer.sv | 42 ++++
 rtl/tdc_fifo_reader.sv | 156 +++++++++++++++
 tb/tb_tdc_fifo_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result path: word geometry, the default
// sync header byte and the FIFO reader state encoding.
package tdc_pkg;

  localparam int         TDC_WORD_W     = 48;
  localparam int         TDC_WORD_BYTES = 6;
  localparam logic [7:0] TDC_SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    POP_WAIT,
    LOAD,
    HDR,
    SEND,
    GUARD,
    WAIT_TX
  } reader_state_t;

endpackage

// File: rtl/tdc_word_serializer.sv
// Holds one popped FIFO word and presents it a byte at a time, LSB first.
// load captures a word and clears the byte counter, shift drops the byte
// just sent, advance steps the byte counter, last flags the final byte.
module tdc_word_serializer
  import tdc_pkg::*;
#(
  parameter int DATA_WIDTH     = TDC_WORD_W,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [7:0]            byte_out,
  output logic                  last
);

  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      byte_cnt;

  // Shift register and byte counter; load wins over shift/advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= data;
      byte_cnt <= '0;
    end else begin
      if (shift)   shreg    <= {8'h00, shreg[DATA_WIDTH-1:8]};
      if (advance) byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign byte_out = shreg[7:0];
  assign last     = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/tdc_fifo_reader.sv
// Consumer of the TDC result FIFO: pops one 48-bit word, then feeds its bytes
// (LSB first) to the UART transmitter over a new_data/busy handshake.
// Handshake: tx_new_data is a one-cycle strobe issued only when tx_busy was
// sampled low; the cycle after a strobe ignores tx_busy so the transmitter
// has time to raise it, then the next byte waits for tx_busy low again.
// Optional macro TDC_SYNC_HEADER_EN prefixes every frame with SYNC_BYTE.
module tdc_fifo_reader
  import tdc_pkg::*;
#(
  parameter int DATA_WIDTH     = TDC_WORD_W,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
`ifdef TDC_SYNC_HEADER_EN
  , parameter logic [7:0] SYNC_BYTE = TDC_SYNC_BYTE
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_new_data,
  output logic [15:0]           words_sent,
  output logic                  reader_busy
);

  reader_state_t state, state_next;
  logic          rd_en_next;
  logic          new_data_next;
  logic [7:0]    data_next;
  logic [15:0]   words_next;
  logic          ser_load, ser_shift, ser_advance, ser_last;
  logic [7:0]    ser_byte;

`ifdef TDC_SYNC_HEADER_EN
  // High between emitting the header and starting data byte 0.
  logic          hdr_phase;
  logic          hdr_set, hdr_clr;
`endif

  tdc_word_serializer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .advance  (ser_advance),
    .data     (fifo_dout),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  // State register plus the registered outputs computed alongside next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fifo_rd_en  <= 1'b0;
      tx_new_data <= 1'b0;
      tx_data     <= 8'h00;
      words_sent  <= 16'h0000;
      reader_busy <= 1'b0;
    end else begin
      state       <= state_next;
      fifo_rd_en  <= rd_en_next;
      tx_new_data <= new_data_next;
      tx_data     <= data_next;
      words_sent  <= words_next;
      reader_busy <= (state_next != IDLE);
    end
  end

`ifdef TDC_SYNC_HEADER_EN
  // Remembers that the byte in flight is the header, not a data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hdr_phase <= 1'b0;
    else if (hdr_set) hdr_phase <= 1'b1;
    else if (hdr_clr) hdr_phase <= 1'b0;
  end
`endif

  // Next-state and output decode; every output defaults to hold or idle.
  always_comb begin
    state_next    = state;
    rd_en_next    = 1'b0;
    new_data_next = 1'b0;
    data_next     = tx_data;
    words_next    = words_sent;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    ser_advance   = 1'b0;
`ifdef TDC_SYNC_HEADER_EN
    hdr_set       = 1'b0;
    hdr_clr       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_next = POP;
          rd_en_next = 1'b1;
        end
      end
      POP:      state_next = POP_WAIT;
      POP_WAIT: state_next = LOAD;
      LOAD: begin
        ser_load = 1'b1;
`ifdef TDC_SYNC_HEADER_EN
        state_next = HDR;
`else
        state_next = SEND;
`endif
      end
`ifdef TDC_SYNC_HEADER_EN
      HDR: begin
        if (!tx_busy) begin
          data_next     = SYNC_BYTE;
          new_data_next = 1'b1;
          hdr_set       = 1'b1;
          state_next    = GUARD;
        end
      end
`endif
      SEND: begin
        if (!tx_busy) begin
          data_next     = ser_byte;
          new_data_next = 1'b1;
          ser_shift     = 1'b1;
          state_next    = GUARD;
        end
      end
      GUARD: state_next = WAIT_TX;
      WAIT_TX: begin
        if (!tx_busy) begin
`ifdef TDC_SYNC_HEADER_EN
          if (hdr_phase) begin
            hdr_clr    = 1'b1;
            state_next = SEND;
          end else
`endif
          if (ser_last) begin
            words_next = words_sent + 16'd1;
            state_next = IDLE;
          end else begin
            ser_advance = 1'b1;
            state_next  = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Bench for tdc_fifo_reader: behavioural FIFO and UART-busy models, a byte
// scoreboard fed from the words pushed into the FIFO, and one task per scenario.
module tb_tdc_fifo_reader;

`ifdef TDC_SYNC_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FRAME_LEN = HDR_N + 6;

  logic        clk, rst, enable, fifo_empty, fifo_rd_en, tx_busy, tx_new_data, reader_busy;
  logic [47:0] fifo_dout;
  logic [7:0]  tx_data;
  logic [15:0] words_sent;

  logic [47:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int checks = 0, errors = 0;
  int pops = 0, strobes = 0, pending = 0, words_total = 0;
  int busy_left = 0, busy_fixed = 3;
  logic force_busy = 1'b0, prev_nd = 1'b0;
  logic [7:0] last_byte = 8'h00, exp_b;

  tdc_fifo_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .words_sent(words_sent),
    .reader_busy(reader_busy)
  );

  always #5 clk = ~clk;

  // Environment on the falling edge: scoreboard, FIFO pops, UART busy model.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_new_data) begin
        strobes++;
        last_byte = tx_data;
        if (prev_nd) begin
          errors++;
          $display("FAIL strobe_width: tx_new_data high %0d cycles, required 1", 2);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no strobe", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          checks++;
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
          end
        end
        pending--;
        busy_left = (busy_fixed < 0) ? int'($urandom_range(0, 4)) : busy_fixed;
      end
      if (fifo_rd_en) begin
        checks++;
        if (fifo_q.size() == 0 || pending != 0 || words_sent !== 16'(pops)) begin
          errors++;
          $display("FAIL pop_rule: fifo_depth=%0d pending_bytes=%0d words_sent=%0d, required depth>0 pending=0 words_sent=%0d",
                   fifo_q.size(), pending, words_sent, pops);
        end
        if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        pops++;
        pending = FRAME_LEN;
      end
      prev_nd = tx_new_data;
    end
    tx_busy = force_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic push_word(input logic [47:0] w);
    fifo_q.push_back(w);
    if (HDR_N == 1) exp_q.push_back(8'hA5);
    for (int i = 0; i < 6; i++) exp_q.push_back(w[8*i +: 8]);
    words_total++;
    fifo_empty = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_sent !== 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (words_sent !== 16'(target)) begin
      errors++;
      $display("FAIL wait_words: words_sent=%0d after %0d cycles, required %0d", words_sent, budget, target);
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (strobes < target) begin
      errors++;
      $display("FAIL wait_strobes: strobes=%0d, required %0d", strobes, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    if (tx_new_data !== 1'b0) begin errors++; $display("FAIL reset_new_data: got %b required 0", tx_new_data); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
    if (words_sent !== 16'h0) begin errors++; $display("FAIL reset_words: got %0d required 0", words_sent); end
    if (reader_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", reader_busy); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (reader_busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_empty: busy=%b rd_en=%b required 0 0", reader_busy, fifo_rd_en);
    end
  endtask

  task automatic test_single_word();
    int n = 0;
    logic seen = 1'b0;
    busy_fixed = 3;
    @(negedge clk);
    push_word(48'h123456789ABC);
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (tx_new_data) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 5) begin
      errors++;
      $display("FAIL latency: first strobe after %0d edges (seen=%b), required 5", n, seen);
    end
    wait_words(words_total, 200);
    checks += 3;
    if (words_sent !== 16'd1) begin errors++; $display("FAIL single_words: got %0d required 1", words_sent); end
    if (pops != 1) begin errors++; $display("FAIL single_pops: got %0d required 1", pops); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_bytes: %0d bytes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    busy_fixed = -1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_word({$urandom, 16'($urandom)});
    wait_words(words_total, 600);
    @(negedge clk);
    checks += 5;
    if (words_sent !== 16'(words_total)) begin errors++; $display("FAIL b2b_words: got %0d required %0d", words_sent, words_total); end
    if (pops != p0 + 3) begin errors++; $display("FAIL b2b_pops: got %0d required %0d", pops - p0, 3); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_bytes: %0d bytes missing, required 0", exp_q.size()); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b required 1", fifo_empty); end
    if (reader_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: reader_busy=%b required 0", reader_busy); end
  endtask

  task automatic test_busy_stall();
    int s0, p0;
    busy_fixed = 3;
    @(negedge clk);
    s0 = strobes;
    push_word(48'h123456789ABC);
    wait_strobes(s0 + HDR_N + 3, 200);
    force_busy = 1'b1;
    p0 = pops;
    s0 = strobes;
    repeat (100) @(negedge clk);
    checks += 3;
    if (strobes != s0) begin errors++; $display("FAIL stall_strobe: %0d strobes while busy, required 0", strobes - s0); end
    if (pops != p0) begin errors++; $display("FAIL stall_pop: %0d pops while busy, required 0", pops - p0); end
    if (reader_busy !== 1'b1) begin errors++; $display("FAIL stall_busy: reader_busy=%b required 1", reader_busy); end
    force_busy = 1'b0;
    wait_strobes(s0 + 1, 50);
    checks++;
    if (last_byte !== 8'h56) begin errors++; $display("FAIL stall_byte3: got %02h required 56", last_byte); end
    wait_words(words_total, 200);
    checks++;
    if (pops != p0) begin errors++; $display("FAIL stall_extra_pop: got %0d required 0", pops - p0); end
  endtask

  task automatic test_enable();
    int p0, n;
    busy_fixed = -1;
    @(negedge clk);
    enable = 1'b0;
    p0 = pops;
    push_word({$urandom, 16'($urandom)});
    push_word({$urandom, 16'($urandom)});
    repeat (30) @(negedge clk);
    checks += 2;
    if (pops != p0) begin errors++; $display("FAIL disabled_pop: got %0d pops required 0", pops - p0); end
    if (reader_busy !== 1'b0) begin errors++; $display("FAIL disabled_busy: got %b required 0", reader_busy); end
    enable = 1'b1;
    n = 0;
    while (pops == p0 && n < 20) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_words(words_total - 1, 300);
    repeat (30) @(negedge clk);
    checks += 3;
    if (pops != p0 + 1) begin errors++; $display("FAIL enable_drop_pops: got %0d required 1", pops - p0); end
    if (exp_q.size() != FRAME_LEN) begin errors++; $display("FAIL enable_drop_bytes: %0d queued, required %0d", exp_q.size(), FRAME_LEN); end
    if (words_sent !== 16'(words_total - 1)) begin errors++; $display("FAIL enable_drop_words: got %0d required %0d", words_sent, words_total - 1); end
    enable = 1'b1;
    wait_words(words_total, 300);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL enable_resume: %0d bytes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int s0;
    busy_fixed = 3;
    @(negedge clk);
    s0 = strobes;
    push_word({$urandom, 16'($urandom)});
    wait_strobes(s0 + HDR_N + 2, 200);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    pending = 0; pops = 0; words_total = 0; busy_left = 0; prev_nd = 1'b0;
    @(posedge clk); #1;
    checks += 4;
    if (tx_new_data !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_strobes: new_data=%b rd_en=%b required 0 0", tx_new_data, fifo_rd_en); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h required 00", tx_data); end
    if (words_sent !== 16'h0) begin errors++; $display("FAIL midrst_words: got %0d required 0", words_sent); end
    if (reader_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", reader_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_word(48'h0000000000FF);
    wait_words(1, 200);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL postrst_bytes: %0d bytes missing, required 0", exp_q.size()); end
    if (pops != 1) begin errors++; $display("FAIL postrst_pops: got %0d required 1", pops); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; enable = 1'b1; fifo_empty = 1'b1;
    fifo_dout = '0; tx_busy = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_stall();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
